// File: rtl/ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle control FSM: opcodes, functs, states, select codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ctrl_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALU operations
  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_NOR  = 4'h5;
  localparam logic [3:0] ALU_SLL  = 4'h6;
  localparam logic [3:0] ALU_SRL  = 4'h7;
  localparam logic [3:0] ALU_SRA  = 4'h8;
  localparam logic [3:0] ALU_SLT  = 4'h9;
  localparam logic [3:0] ALU_SLTU = 4'hA;
  localparam logic [3:0] ALU_LUI  = 4'hB;

  // Next-PC select
  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_JMP = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  // Register write-data select
  localparam logic [1:0] WD_ALU  = 2'b00;
  localparam logic [1:0] WD_MEM  = 2'b01;
  localparam logic [1:0] WD_LINK = 2'b10;
  localparam logic [1:0] WD_SLT  = 2'b11;

  // Destination register select
  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  // Memory access size: [1:0] size, [2] unsigned load
  localparam logic [7:0] WHB_W  = 8'h00;
  localparam logic [7:0] WHB_H  = 8'h01;
  localparam logic [7:0] WHB_B  = 8'h02;
  localparam logic [7:0] WHB_HU = 8'h05;
  localparam logic [7:0] WHB_BU = 8'h06;

  typedef enum logic [3:0] {
    FETCH, DCD, EXE, MA, MRD, MWB, MWR, AWB, BR, JMP
  } state_t;

  typedef enum logic [2:0] {
    CL_NOP, CL_RALU, CL_IALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JUMP
  } iclass_t;

  // Everything the FSM needs to know about the instruction in IR
  typedef struct packed {
    iclass_t    cls;
    logic [3:0] alu_op;
    logic       ext_op;
    logic       sel_a;
    logic       sel_b;
    logic [1:0] reg_dst;
    logic [7:0] whb;
    logic       is_bne;
    logic       is_jal;
    logic [1:0] jmp_npc;
  } dec_t;

  // Full control word driven towards the datapath
  typedef struct packed {
    logic [1:0] npc_op;
    logic       pc_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       mem_wr;
    logic [1:0] wd_sel;
    logic [1:0] reg_dst;
    logic       ext_op;
    logic       alu_sel_a;
    logic       alu_sel_b;
    logic [3:0] alu_op;
    logic [7:0] whb;
  } ctrl_t;

endpackage

// File: rtl/ctrl_fsm_if.sv
// Control bundle between the control FSM (master) and the datapath (slave).
// Latency: n/a (wires only).
// Backpressure: none; the datapath always accepts the control word.
interface ctrl_fsm_if;
  logic [31:0] Im;
  logic [2:0]  Zero;
  logic [1:0]  NPCOp;
  logic        PCWr;
  logic        IRWr;
  logic        RegWr;
  logic        MemWr;
  logic [1:0]  WDSel;
  logic [1:0]  RegDst;
  logic        ExtOp;
  logic        ALUSelA;
  logic        ALUSelB;
  logic [3:0]  ALUOp;
  logic [7:0]  whb;

  modport master (
    input  Im, Zero,
    output NPCOp, PCWr, IRWr, RegWr, MemWr, WDSel, RegDst,
           ExtOp, ALUSelA, ALUSelB, ALUOp, whb
  );

  modport slave (
    output Im, Zero,
    input  NPCOp, PCWr, IRWr, RegWr, MemWr, WDSel, RegDst,
           ExtOp, ALUSelA, ALUSelB, ALUOp, whb
  );
endinterface

// File: rtl/ctrl_fsm_decode.sv
// Combinational instruction decoder: IR word -> class, ALU op, extension, destination, access size.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] im,
  output dec_t        dec
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_bits;

  assign op = im[31:26];
  assign fn = im[5:0];
  // Register fields and immediate are consumed by the datapath, not by control
  assign unused_bits = ^im[25:6];

  // Map opcode/funct to class and per-instruction controls; unknown encodings become NOPs
  always_comb begin
    dec         = '0;
    dec.cls     = CL_NOP;
    dec.alu_op  = ALU_ADD;
    dec.reg_dst = RD_RT;
    dec.jmp_npc = NPC_JMP;
    case (op)
      OP_RTYPE: begin
        dec.cls     = CL_RALU;
        dec.reg_dst = RD_RD;
        case (fn)
          FN_SLL:          begin dec.alu_op = ALU_SLL; dec.sel_a = 1'b1; dec.sel_b = 1'b1; end
          FN_SRL:          begin dec.alu_op = ALU_SRL; dec.sel_a = 1'b1; dec.sel_b = 1'b1; end
          FN_SRA:          begin dec.alu_op = ALU_SRA; dec.sel_a = 1'b1; dec.sel_b = 1'b1; end
          FN_ADD, FN_ADDU: dec.alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: dec.alu_op = ALU_SUB;
          FN_AND:          dec.alu_op = ALU_AND;
          FN_OR:           dec.alu_op = ALU_OR;
          FN_XOR:          dec.alu_op = ALU_XOR;
          FN_NOR:          dec.alu_op = ALU_NOR;
          FN_SLT:          dec.alu_op = ALU_SLT;
          FN_SLTU:         dec.alu_op = ALU_SLTU;
          FN_JR: begin
            dec.cls     = CL_JUMP;
            dec.reg_dst = RD_RT;
            dec.jmp_npc = NPC_JR;
          end
          default: begin
            dec.cls     = CL_NOP;
            dec.reg_dst = RD_RT;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        dec.cls    = CL_IALU;
        dec.sel_b  = 1'b1;
        // Logical immediates are zero-extended, everything else sign-extends
        dec.ext_op = !(op == OP_ANDI || op == OP_ORI || op == OP_XORI);
        case (op)
          OP_SLTI:  dec.alu_op = ALU_SLT;
          OP_SLTIU: dec.alu_op = ALU_SLTU;
          OP_ANDI:  dec.alu_op = ALU_AND;
          OP_ORI:   dec.alu_op = ALU_OR;
          OP_XORI:  dec.alu_op = ALU_XOR;
          OP_LUI:   dec.alu_op = ALU_LUI;
          default:  dec.alu_op = ALU_ADD;
        endcase
      end
      OP_LW:  begin dec.cls = CL_LOAD;  dec.whb = WHB_W;  end
      OP_LH:  begin dec.cls = CL_LOAD;  dec.whb = WHB_H;  end
      OP_LHU: begin dec.cls = CL_LOAD;  dec.whb = WHB_HU; end
      OP_LB:  begin dec.cls = CL_LOAD;  dec.whb = WHB_B;  end
      OP_LBU: begin dec.cls = CL_LOAD;  dec.whb = WHB_BU; end
      OP_SW:  begin dec.cls = CL_STORE; dec.whb = WHB_W;  end
      OP_SH:  begin dec.cls = CL_STORE; dec.whb = WHB_H;  end
      OP_SB:  begin dec.cls = CL_STORE; dec.whb = WHB_B;  end
      OP_BEQ: begin dec.cls = CL_BRANCH; dec.alu_op = ALU_SUB; end
      OP_BNE: begin dec.cls = CL_BRANCH; dec.alu_op = ALU_SUB; dec.is_bne = 1'b1; end
      OP_J:   dec.cls = CL_JUMP;
      OP_JAL: begin dec.cls = CL_JUMP; dec.is_jal = 1'b1; dec.reg_dst = RD_RA; end
      default: dec.cls = CL_NOP;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle control FSM: sequences FETCH/DCD/execute states and drives datapath enables and selects.
// Latency: 2-5 cycles per instruction (NOP 2, branch/jump 3, ALU/store 4, load 5).
// Backpressure: none; advances every cycle, synchronous active-low reset aborts and returns to FETCH.
module ctrl_fsm
  import ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  ctrl_fsm_if.master    bus
);

  dec_t   dec;
  state_t state;
  ctrl_t  out_q;
  ctrl_t  out_c;
  logic   br_take;
  logic   unused_zero;

  instr_decode u_decode (
    .im  (bus.Im),
    .dec (dec)
  );

  function automatic state_t next_state(input state_t s, input dec_t d);
    state_t n;
    n = FETCH;
    case (s)
      FETCH: n = DCD;
      DCD: begin
        case (d.cls)
          CL_RALU, CL_IALU:  n = EXE;
          CL_LOAD, CL_STORE: n = MA;
          CL_BRANCH:         n = BR;
          CL_JUMP:           n = JMP;
          default:           n = FETCH;
        endcase
      end
      EXE:     n = AWB;
      MA:      n = (d.cls == CL_STORE) ? MWR : MRD;
      MRD:     n = MWB;
      default: n = FETCH;
    endcase
    return n;
  endfunction

  // Control word for a state; branch PCWr is resolved separately from Zero
  function automatic ctrl_t state_outs(input state_t s, input dec_t d);
    ctrl_t o;
    o = '0;
    case (s)
      FETCH: begin
        o.pc_wr  = 1'b1;
        o.ir_wr  = 1'b1;
        o.npc_op = NPC_PC4;
      end
      EXE, AWB: begin
        o.alu_op    = d.alu_op;
        o.ext_op    = d.ext_op;
        o.alu_sel_a = d.sel_a;
        o.alu_sel_b = d.sel_b;
        if (s == AWB) begin
          o.reg_wr  = 1'b1;
          o.wd_sel  = WD_ALU;
          o.reg_dst = d.reg_dst;
        end
      end
      MA: begin
        o.alu_op    = ALU_ADD;
        o.alu_sel_b = 1'b1;
        o.ext_op    = 1'b1;
      end
      MWR: begin
        o.mem_wr = 1'b1;
        o.whb    = d.whb;
      end
      MRD: o.whb = d.whb;
      MWB: begin
        o.reg_wr  = 1'b1;
        o.wd_sel  = WD_MEM;
        o.reg_dst = RD_RT;
        o.whb     = d.whb;
      end
      BR: begin
        o.alu_op = ALU_SUB;
        o.npc_op = NPC_BR;
      end
      JMP: begin
        o.pc_wr  = 1'b1;
        o.npc_op = d.jmp_npc;
        if (d.is_jal) begin
          o.reg_wr  = 1'b1;
          o.reg_dst = RD_RA;
          o.wd_sel  = WD_LINK;
        end
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  // State register with look-ahead registered outputs; IR is stable from DCD to the end of the instruction
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      out_q <= state_outs(FETCH, dec);
    end else begin
      state <= next_state(state, dec);
      out_q <= state_outs(next_state(state, dec), dec);
    end
  end

  // Branch decision uses this cycle's flags, so it bypasses the output register
  assign br_take     = (state == BR) && (dec.is_bne ? !bus.Zero[0] : bus.Zero[0]);
  assign unused_zero = ^bus.Zero[2:1];

  // Merge branch PCWr and silence every output while reset is held low
  always_comb begin
    out_c       = out_q;
    out_c.pc_wr = out_q.pc_wr | br_take;
    if (!reset) out_c = '0;
  end

  assign bus.NPCOp   = out_c.npc_op;
  assign bus.PCWr    = out_c.pc_wr;
  assign bus.IRWr    = out_c.ir_wr;
  assign bus.RegWr   = out_c.reg_wr;
  assign bus.MemWr   = out_c.mem_wr;
  assign bus.WDSel   = out_c.wd_sel;
  assign bus.RegDst  = out_c.reg_dst;
  assign bus.ExtOp   = out_c.ext_op;
  assign bus.ALUSelA = out_c.alu_sel_a;
  assign bus.ALUSelB = out_c.alu_sel_b;
  assign bus.ALUOp   = out_c.alu_op;
  assign bus.whb     = out_c.whb;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Bench for ctrl_fsm: per-instruction cycle model, directed corner cases, then random instruction streams.
// Latency: n/a.
// Backpressure: n/a.
module tb_ctrl_fsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ctrl_fsm_if bus();

  ctrl_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [24:0] exp_vec = '0;
  logic        exp_vld = 1'b0;
  string       cur_tag = "idle";
  int          cur_k   = 0;

  // Output vector: {NPCOp,PCWr,IRWr,RegWr,MemWr,WDSel,RegDst,ExtOp,ALUSelA,ALUSelB,ALUOp,whb}
  wire [24:0] dut_vec = {bus.NPCOp, bus.PCWr, bus.IRWr, bus.RegWr, bus.MemWr, bus.WDSel,
                         bus.RegDst, bus.ExtOp, bus.ALUSelA, bus.ALUSelB, bus.ALUOp, bus.whb};

  localparam logic [31:0] I_ADDU = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
  localparam logic [31:0] I_LBU  = {6'h24, 5'd0, 5'd4, 16'd3};
  localparam logic [31:0] I_BEQ  = {6'h04, 5'd1, 5'd2, 16'h0004};
  localparam logic [31:0] I_BNE  = {6'h05, 5'd1, 5'd2, 16'h0004};
  localparam logic [31:0] I_JAL  = {6'h03, 26'h0000100};
  localparam logic [31:0] I_J    = {6'h02, 26'h0000040};
  localparam logic [31:0] I_JR   = {6'h00, 5'd31, 15'd0, 6'h08};
  localparam logic [31:0] I_SLL  = {6'h00, 5'd0, 5'd3, 5'd2, 5'd4, 6'h00};
  localparam logic [31:0] I_ANDI = {6'h0C, 5'd3, 5'd2, 16'hFFFF};
  localparam logic [31:0] I_ADDI = {6'h08, 5'd3, 5'd2, 16'h8001};
  localparam logic [31:0] I_LW   = {6'h23, 5'd1, 5'd6, 16'd4};
  localparam logic [31:0] I_SH   = {6'h29, 5'd1, 5'd6, 16'd2};
  localparam logic [31:0] I_SW   = {6'h2B, 5'd1, 5'd5, 16'd8};
  localparam logic [31:0] I_UNDF = {6'h3F, 26'h0};

  // ---------------- behavioural model ----------------
  // Class: 0 NOP, 1 R-ALU, 2 I-ALU, 3 load, 4 store, 5 branch, 6 jump
  function automatic int mclass(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) begin
      if (fn inside {6'h00, 6'h02, 6'h03, [6'h20:6'h27], 6'h2A, 6'h2B}) return 1;
      if (fn == 6'h08) return 6;
      return 0;
    end
    if (op inside {[6'h08:6'h0F]}) return 2;
    if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return 3;
    if (op inside {6'h28, 6'h29, 6'h2B}) return 4;
    if (op inside {6'h04, 6'h05}) return 5;
    if (op inside {6'h02, 6'h03}) return 6;
    return 0;
  endfunction

  function automatic int mlen(input logic [31:0] ins);
    case (mclass(ins))
      1, 2, 4: return 4;
      3:       return 5;
      5, 6:    return 3;
      default: return 2;
    endcase
  endfunction

  function automatic logic [3:0] malu(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) begin
      case (fn)
        6'h00: return 4'd6;
        6'h02: return 4'd7;
        6'h03: return 4'd8;
        6'h22, 6'h23: return 4'd1;
        6'h24: return 4'd2;
        6'h25: return 4'd3;
        6'h26: return 4'd4;
        6'h27: return 4'd5;
        6'h2A: return 4'd9;
        6'h2B: return 4'd10;
        default: return 4'd0;
      endcase
    end
    case (op)
      6'h0A: return 4'd9;
      6'h0B: return 4'd10;
      6'h0C: return 4'd2;
      6'h0D: return 4'd3;
      6'h0E: return 4'd4;
      6'h0F: return 4'd11;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [7:0] mwhb(input logic [5:0] op);
    case (op)
      6'h21, 6'h29: return 8'h01;
      6'h25:        return 8'h05;
      6'h20, 6'h28: return 8'h02;
      6'h24:        return 8'h06;
      default:      return 8'h00;
    endcase
  endfunction

  // Expected outputs in cycle k (0 = the FETCH cycle) of instruction ins
  function automatic logic [24:0] model_out(input logic [31:0] ins, input int k, input logic [2:0] z);
    logic [1:0] npc, wd, rd;
    logic       pcw, irw, rw, mw, ext, sa, sb;
    logic [3:0] alu;
    logic [7:0] w;
    logic [5:0] op;
    int         cls;
    npc = 0; wd = 0; rd = 0; pcw = 0; irw = 0; rw = 0; mw = 0;
    ext = 0; sa = 0; sb = 0; alu = 0; w = 0;
    op  = ins[31:26];
    cls = mclass(ins);
    if (k == 0) begin
      pcw = 1; irw = 1;
    end else if (k >= 2) begin
      case (cls)
        1, 2: begin
          alu = malu(ins);
          if (cls == 1) begin
            sa = ins[5:0] inside {6'h00, 6'h02, 6'h03};
            sb = sa;
          end else begin
            sb  = 1;
            ext = !(op inside {6'h0C, 6'h0D, 6'h0E});
          end
          if (k == 3) begin
            rw = 1;
            rd = (cls == 1) ? 2'b01 : 2'b00;
          end
        end
        3: begin
          if (k == 2) begin sb = 1; ext = 1; end
          else w = mwhb(op);
          if (k == 4) begin rw = 1; wd = 2'b01; end
        end
        4: begin
          if (k == 2) begin sb = 1; ext = 1; end
          else begin mw = 1; w = mwhb(op); end
        end
        5: begin
          alu = 4'd1;
          npc = 2'b01;
          pcw = (op == 6'h04) ? z[0] : !z[0];
        end
        6: begin
          pcw = 1;
          npc = (op == 6'h00) ? 2'b11 : 2'b10;
          if (op == 6'h03) begin rw = 1; rd = 2'b10; wd = 2'b10; end
        end
        default: ;
      endcase
    end
    return {npc, pcw, irw, rw, mw, wd, rd, ext, sa, sb, alu, w};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [5:0]  fns [0:14];
    logic [5:0]  ops [0:20];
    int          r;
    fns = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h3F};
    ops = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
            6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h3F};
    w = $urandom;
    r = $urandom_range(0, 9);
    if (r <= 2) begin
      w[31:26] = 6'h00;
      if (r != 2) w[5:0] = fns[$urandom_range(0, 14)];
    end else if (r <= 8) begin
      w[31:26] = ops[$urandom_range(0, 20)];
    end
    return w;
  endfunction

  // ---------------- checking ----------------
  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Single compare point, half a cycle after the driver has set up expectations
  always @(negedge clk) begin
    if (exp_vld) begin
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", cur_tag, cur_k, dut_vec, exp_vec);
      end
    end
  end

  // Run one instruction; if abort_k >= 0, pull reset low in that cycle and hold it two more cycles
  task automatic run_instr(input logic [31:0] ins, input string tag, input int abort_k, input int zbit);
    int         n;
    logic [2:0] zv;
    n = mlen(ins);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        bus.Im = ins;
        reset  = 1'b1;
      end
      zv = 3'($urandom);
      if (zbit >= 0) zv[0] = zbit[0];
      bus.Zero = zv;
      cur_tag  = tag;
      cur_k    = k;
      if (k == abort_k) begin
        reset   = 1'b0;
        exp_vec = '0;
        exp_vld = 1'b1;
        for (int h = 0; h < 2; h++) begin
          @(posedge clk); #1;
          bus.Zero = 3'($urandom);
          cur_k    = k + 1 + h;
        end
        return;
      end
      exp_vec = model_out(ins, k, zv);
      exp_vld = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [24:0] v;
    logic [31:0] ins;
    int          ab;

    reset    = 1'b0;
    bus.Im   = '0;
    bus.Zero = '0;

    // Pin the model with hand-worked values
    check_val("model addu len", mlen(I_ADDU), 4);
    check_val("model lbu len", mlen(I_LBU), 5);
    check_val("model sw len", mlen(I_SW), 4);
    check_val("model beq len", mlen(I_BEQ), 3);
    check_val("model undef len", mlen(I_UNDF), 2);
    check_val("model addu AWB", model_out(I_ADDU, 3, 3'b000),
              {7'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00});
    v = model_out(I_LBU, 3, 3'b000);
    check_val("model lbu MRD whb", {24'd0, v[7:0]}, 32'h06);
    check_val("model lbu MWB", model_out(I_LBU, 4, 3'b000),
              {7'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h06});
    check_val("model beq taken", model_out(I_BEQ, 2, 3'b001),
              {7'd0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'h1, 8'h00});
    check_val("model bne not taken", model_out(I_BNE, 2, 3'b001),
              {7'd0, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'h1, 8'h00});
    check_val("model jal JMP", model_out(I_JAL, 2, 3'b000),
              {7'd0, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00});
    check_val("model fetch", model_out(I_UNDF, 0, 3'b000),
              {7'd0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00});

    // Power-on reset: outputs must stay 0 while reset is low
    repeat (2) @(posedge clk);
    #1;
    cur_tag = "reset";
    exp_vec = '0;
    exp_vld = 1'b1;
    repeat (2) @(posedge clk);

    // Directed corner cases
    run_instr(I_ADDU, "addu", -1, -1);
    run_instr(I_LBU,  "lbu",  -1, -1);
    run_instr(I_BEQ,  "beq z1", -1, 1);
    run_instr(I_BEQ,  "beq z0", -1, 0);
    run_instr(I_BNE,  "bne z1", -1, 1);
    run_instr(I_BNE,  "bne z0", -1, 0);
    run_instr(I_JAL,  "jal", -1, -1);
    run_instr(I_J,    "j", -1, -1);
    run_instr(I_JR,   "jr", -1, -1);
    run_instr(I_SLL,  "sll", -1, -1);
    run_instr(I_ANDI, "andi", -1, -1);
    run_instr(I_ADDI, "addi", -1, -1);
    run_instr(I_LW,   "lw", -1, -1);
    run_instr(I_SH,   "sh", -1, -1);
    run_instr(I_UNDF, "undef", -1, -1);
    run_instr(I_SW,   "sw abort MA", 2, -1);
    run_instr(I_ADDU, "addu after reset", -1, -1);
    run_instr(I_SW,   "sw", -1, -1);

    // Random instruction stream with occasional aborts
    for (int i = 0; i < 400; i++) begin
      ins = rand_instr();
      ab  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, mlen(ins) - 1) : -1;
      run_instr(ins, "random", ab, -1);
    end

    @(posedge clk); #1;
    exp_vld = 1'b0;
    @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
